// File: rtl/wb_sdram_burst_reader.sv
// Wishbone classic read master: fetches cmd_len words into a FIFO stream.
// Optional per-beat ack timeout enabled by defining WB_TIMEOUT_EN.
module wb_sdram_burst_reader #(
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 8
`ifdef WB_TIMEOUT_EN
  , parameter int TIMEOUT  = 255
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, GAP, FIN} state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic             push, pop;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr[1:0];

`ifdef WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
`ifdef WB_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
`ifdef WB_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    push    = 1'b0;
`ifdef WB_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = {cmd_addr[31:2], 2'b00};
          rem_d   = cmd_len;
          state_d = (cmd_len == '0) ? FIN : GAP;
`ifdef WB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      // one read in flight at most, so a free slot now means no overflow
      GAP: begin
        if (cnt_q < FULL) begin
          state_d = REQ;
`ifdef WB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      REQ: begin
        if (wbm_ack_i) begin
          push    = 1'b1;
          addr_d  = addr_q + 32'd4;
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? FIN : GAP;
        end
`ifdef WB_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = FIN;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pop = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wbm_dat_i;
  end

  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rptr_q];

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign wbm_cyc_o = (state_q == REQ);
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = addr_q;

endmodule

// File: tb/tb_wb_sdram_burst_reader.sv
// Bench for wb_sdram_burst_reader: latency-programmable slave, stream
// monitor and an arithmetic model of the expected address/data sequence.
module tb_wb_sdram_burst_reader;

  localparam int DEPTH = 4;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_i;
  logic        wbm_ack_i;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        busy, done, err;

  int n_chk = 0;
  int n_fail = 0;

  wb_sdram_burst_reader #(
    .LEN_W(16),
    .FIFO_DEPTH(DEPTH)
`ifdef WB_TIMEOUT_EN
    , .TIMEOUT(20)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave model
  int lat = 5;
  int ack_stop = -1;
  int sl_acks = 0;
  int wcnt = 0;
  bit armed = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      wbm_ack_i <= 1'b0;
      wcnt      <= 0;
      armed     <= 1'b1;
    end else begin
      wbm_ack_i <= 1'b0;
      if (!wbm_cyc_o) begin
        armed <= 1'b1;
        wcnt  <= 0;
      end else if (armed && !wbm_ack_i) begin
        if (wcnt >= lat - 1 && (ack_stop < 0 || sl_acks < ack_stop)) begin
          wbm_ack_i <= 1'b1;
          wbm_dat_i <= wbm_adr_o ^ K;
          armed     <= 1'b0;
          sl_acks   <= sl_acks + 1;
        end
        wcnt <= wcnt + 1;
      end
    end
  end

  // monitor
  logic [31:0] bus_q[$];
  logic [31:0] got_q[$];
  int mon_acks = 0, mon_dones = 0, mon_cyc = 0, mon_viol = 0;
  int run = 0, last_run = 0;
  logic prev_cyc = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_adr = '0;

  always @(posedge clk) begin
    if (!rst) begin
      if (wbm_cyc_o && wbm_ack_i) begin
        mon_acks <= mon_acks + 1;
        bus_q.push_back(wbm_adr_o);
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (done) mon_dones <= mon_dones + 1;
      if (wbm_cyc_o) mon_cyc <= mon_cyc + 1;
      if (wbm_stb_o !== wbm_cyc_o || wbm_we_o !== 1'b0 ||
          wbm_sel_o !== 4'hF)
        mon_viol <= mon_viol + 1;
      else if (prev_cyc && prev_ack && wbm_cyc_o)
        mon_viol <= mon_viol + 1;
      else if (prev_cyc && !prev_ack && wbm_cyc_o &&
               wbm_adr_o !== prev_adr)
        mon_viol <= mon_viol + 1;
      if (wbm_cyc_o) run <= run + 1;
      else if (run > 0) begin
        last_run <= run;
        run <= 0;
      end
    end
    prev_cyc <= wbm_cyc_o;
    prev_ack <= wbm_ack_i;
    prev_adr <= wbm_adr_o;
  end

  // reference model
  function automatic logic [31:0] exp_addr(input logic [31:0] b, input int i);
    return (b & 32'hFFFF_FFFC) + 32'(4 * i);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] b, input int i);
    return exp_addr(b, i) ^ K;
  endfunction

  task automatic run_cmd(input logic [31:0] a, input logic [15:0] l);
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit rnd,
                           output bit ok, output int n);
    ok = 1'b0;
    for (n = 0; n < bound; n++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (rnd) out_ready = 1'($urandom % 2);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200 && out_valid; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (wbm_cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc got %b want 0", wbm_cyc_o); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    n_chk++; if (wbm_adr_o !== 32'h0) begin n_fail++; $display("FAIL reset_adr got %h want 0", wbm_adr_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int b0, g0, a0, d0, v0, n;
    bit ok;
    logic [31:0] base;
    base = 32'h3800_0003;
    lat = 5;
    ack_stop = -1;
    out_ready = 1'b1;
    b0 = bus_q.size(); g0 = got_q.size();
    a0 = mon_acks; d0 = mon_dones; v0 = mon_viol;
    run_cmd(base, 16'd4);
    wait_done(500, 1'b0, ok, n);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_done got timeout want pulse"); end
    drain();
    n_chk++; if (bus_q.size() - b0 != 4) begin n_fail++; $display("FAIL basic_nbus got %0d want 4", bus_q.size() - b0); end
    n_chk++; if (got_q.size() - g0 != 4) begin n_fail++; $display("FAIL basic_nword got %0d want 4", got_q.size() - g0); end
    for (int i = 0; i < 4 && b0 + i < bus_q.size(); i++) begin
      n_chk++;
      if (bus_q[b0+i] !== exp_addr(base, i)) begin
        n_fail++; $display("FAIL basic_addr%0d got %h want %h", i, bus_q[b0+i], exp_addr(base, i));
      end
    end
    for (int i = 0; i < 4 && g0 + i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[g0+i] !== exp_word(base, i)) begin
        n_fail++; $display("FAIL basic_data%0d got %h want %h", i, got_q[g0+i], exp_word(base, i));
      end
    end
    n_chk++; if (mon_acks - a0 != 4) begin n_fail++; $display("FAIL basic_acks got %0d want 4", mon_acks - a0); end
    n_chk++; if (mon_dones - d0 != 1) begin n_fail++; $display("FAIL basic_dones got %0d want 1", mon_dones - d0); end
    n_chk++; if (mon_viol != v0) begin n_fail++; $display("FAIL basic_protocol got %0d violations want 0", mon_viol - v0); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b want 0", busy); end
  endtask

  task automatic test_random();
    int b0, g0, d0, v0, n, len;
    bit ok;
    logic [31:0] base;
    for (int it = 0; it < 6; it++) begin
      base = (it == 0) ? 32'hFFFF_FFF6 : $urandom;
      len  = (it == 0) ? 5 : $urandom_range(1, 9);
      lat  = $urandom_range(1, 4);
      b0 = bus_q.size(); g0 = got_q.size();
      d0 = mon_dones; v0 = mon_viol;
      run_cmd(base, 16'(len));
      wait_done(2000, 1'b1, ok, n);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL rand%0d_done got timeout want pulse", it); end
      drain();
      n_chk++; if (got_q.size() - g0 != len) begin n_fail++; $display("FAIL rand%0d_nword got %0d want %0d", it, got_q.size() - g0, len); end
      for (int i = 0; i < len && b0 + i < bus_q.size(); i++) begin
        n_chk++;
        if (bus_q[b0+i] !== exp_addr(base, i)) begin
          n_fail++; $display("FAIL rand%0d_addr%0d got %h want %h", it, i, bus_q[b0+i], exp_addr(base, i));
        end
      end
      for (int i = 0; i < len && g0 + i < got_q.size(); i++) begin
        n_chk++;
        if (got_q[g0+i] !== exp_word(base, i)) begin
          n_fail++; $display("FAIL rand%0d_data%0d got %h want %h", it, i, got_q[g0+i], exp_word(base, i));
        end
      end
      n_chk++; if (mon_dones - d0 != 1) begin n_fail++; $display("FAIL rand%0d_dones got %0d want 1", it, mon_dones - d0); end
      n_chk++; if (mon_viol != v0) begin n_fail++; $display("FAIL rand%0d_protocol got %0d violations want 0", it, mon_viol - v0); end
    end
  endtask

  task automatic test_backpressure();
    int g0, a0, n;
    bit ok;
    logic [31:0] base, head;
    base = $urandom & 32'hFFFF_FF00;
    lat = 2;
    out_ready = 1'b0;
    g0 = got_q.size(); a0 = mon_acks;
    run_cmd(base, 16'd8);
    repeat (80) @(negedge clk);
    n_chk++; if (mon_acks - a0 != DEPTH) begin n_fail++; $display("FAIL bp_acks_held got %0d want %0d", mon_acks - a0, DEPTH); end
    n_chk++; if (wbm_cyc_o !== 1'b0) begin n_fail++; $display("FAIL bp_cyc_held got %b want 0", wbm_cyc_o); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy_held got %b want 1", busy); end
    n_chk++; if (out_data !== exp_word(base, 0)) begin n_fail++; $display("FAIL bp_head got %h want %h", out_data, exp_word(base, 0)); end
    head = out_data;
    repeat (3) @(negedge clk);
    n_chk++; if (out_data !== head || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stable got %h/%b want %h/1", out_data, out_valid, head); end
    out_ready = 1'b1;
    wait_done(1000, 1'b0, ok, n);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_done got timeout want pulse"); end
    drain();
    n_chk++; if (mon_acks - a0 != 8) begin n_fail++; $display("FAIL bp_acks got %0d want 8", mon_acks - a0); end
    n_chk++; if (got_q.size() - g0 != 8) begin n_fail++; $display("FAIL bp_nword got %0d want 8", got_q.size() - g0); end
    for (int i = 0; i < 8 && g0 + i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[g0+i] !== exp_word(base, i)) begin
        n_fail++; $display("FAIL bp_data%0d got %h want %h", i, got_q[g0+i], exp_word(base, i));
      end
    end
  endtask

  task automatic test_zero_len();
    int c0, d0, n;
    bit ok;
    c0 = mon_cyc; d0 = mon_dones;
    run_cmd(32'h1234_5678, 16'd0);
    wait_done(10, 1'b0, ok, n);
    n_chk++; if (!ok || n > 1) begin n_fail++; $display("FAIL zero_done_delay got ok=%0d n=%0d want ok=1 n<=1", ok, n); end
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL zero_idle got busy=%b rdy=%b want 0/1", busy, cmd_ready); end
    repeat (3) @(negedge clk);
    n_chk++; if (mon_cyc != c0) begin n_fail++; $display("FAIL zero_cyc got %0d cycles want 0", mon_cyc - c0); end
    n_chk++; if (mon_dones - d0 != 1) begin n_fail++; $display("FAIL zero_dones got %0d want 1", mon_dones - d0); end
  endtask

  task automatic test_reset_mid();
    int a0, g0, n;
    bit ok;
    logic [31:0] base;
    lat = 2;
    out_ready = 1'b0;
    a0 = mon_acks;
    run_cmd(32'h3800_0100, 16'd16);
    for (n = 0; n < 300 && mon_acks - a0 < 3; n++) @(negedge clk);
    n_chk++; if (mon_acks - a0 != 3) begin n_fail++; $display("FAIL rmid_acks got %0d want 3", mon_acks - a0); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_chk++; if (wbm_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rmid_cyc got %b want 0", wbm_cyc_o); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = $urandom;
    out_ready = 1'b1;
    g0 = got_q.size();
    run_cmd(base, 16'd1);
    wait_done(200, 1'b0, ok, n);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rmid_next_done got timeout want pulse"); end
    drain();
    n_chk++; if (got_q.size() - g0 != 1) begin n_fail++; $display("FAIL rmid_next_nword got %0d want 1", got_q.size() - g0); end
    if (got_q.size() > g0) begin
      n_chk++;
      if (got_q[g0] !== exp_word(base, 0)) begin
        n_fail++; $display("FAIL rmid_next_data got %h want %h", got_q[g0], exp_word(base, 0));
      end
    end
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    int a0, d0, n;
    bit ok;
    logic [31:0] base;
    base = 32'h3800_0200;
    lat = 3;
    out_ready = 1'b0;
    a0 = mon_acks; d0 = mon_dones;
    ack_stop = sl_acks + 1;
    run_cmd(base, 16'd5);
    wait_done(300, 1'b0, ok, n);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL tmo_done got timeout want pulse"); end
    @(negedge clk);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b want 1", err); end
    n_chk++; if (last_run != 20) begin n_fail++; $display("FAIL tmo_cyc_len got %0d want 20", last_run); end
    n_chk++; if (mon_acks - a0 != 1) begin n_fail++; $display("FAIL tmo_acks got %0d want 1", mon_acks - a0); end
    n_chk++; if (mon_dones - d0 != 1) begin n_fail++; $display("FAIL tmo_dones got %0d want 1", mon_dones - d0); end
    n_chk++; if (out_valid !== 1'b1 || out_data !== exp_word(base, 0)) begin n_fail++; $display("FAIL tmo_fifo_head got %b/%h want 1/%h", out_valid, out_data, exp_word(base, 0)); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_fifo_one got %b want 0", out_valid); end
    ack_stop = -1;
    run_cmd(base, 16'd1);
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear got %b want 0", err); end
    wait_done(200, 1'b0, ok, n);
    drain();
  endtask
`endif

  initial begin
    #500_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
